// File: rtl/ttl_sync_pkg.sv
// Shared types and constants for the clock-enable-synchronous TTL models.
package ttl_sync_pkg;

  typedef enum logic [1:0] {
    M_HOLD = 2'b00,
    M_SHR  = 2'b01,
    M_SHL  = 2'b10,
    M_LOAD = 2'b11
  } ttl299_mode_t;

  localparam logic [7:0] OUT_DISABLED = 8'hFF;

endpackage

// File: rtl/cen_edge_det.sv
// Rising-edge detector for an emulated chip clock sampled on the system clock.
module cen_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic cen,
  output logic cen_rise_o
);

  logic last_cen_q;
  logic last_cen_d;

  assign last_cen_d = cen;

  // Resetting to 1 means a cen already high at reset release is not an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_cen_q <= 1'b1;
    end else begin
      last_cen_q <= last_cen_d;
    end
  end

  assign cen_rise_o = cen & ~last_cen_q;

endmodule

// File: rtl/ttl_74299_sync_nohizout.sv
// 74LS299 8-bit universal shift/storage register, cen-edge synchronous, split I/O pins.
module ttl_74299_sync_nohizout
  import ttl_sync_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic       MRn,
  input  logic       S0,
  input  logic       S1,
  input  logic       OE1n,
  input  logic       OE2n,
  input  logic       DS0,
  input  logic       DS7,
  input  logic [7:0] IO_in,
  output logic [7:0] IO_out,
  output logic       Q0s,
  output logic       Q7s
);

  logic         cen_rise_s;
  logic [7:0]   q_q;
  logic [7:0]   q_d;
  ttl299_mode_t mode_s;

  cen_edge_det u_edge (
    .clk        (clk),
    .rst        (rst),
    .cen        (cen),
    .cen_rise_o (cen_rise_s)
  );

  assign mode_s = ttl299_mode_t'({S1, S0});

  // Master reset beats the chip edge; without an edge the register holds.
  always_comb begin
    q_d = q_q;
    if (!MRn) begin
      q_d = 8'h00;
    end else if (cen_rise_s) begin
      case (mode_s)
        M_HOLD:  q_d = q_q;
        M_SHR:   q_d = {q_q[6:0], DS0};
        M_SHL:   q_d = {DS7, q_q[7:1]};
        M_LOAD:  q_d = IO_in;
        default: q_d = q_q;
      endcase
    end else begin
      q_d = q_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= 8'h00;
    end else begin
      q_q <= q_d;
    end
  end

  // Load mode turns the pins into inputs, so the output side reads as released.
  assign IO_out = (OE1n | OE2n | (S1 & S0)) ? OUT_DISABLED : q_q;
  assign Q0s    = q_q[0];
  assign Q7s    = q_q[7];

endmodule

// File: tb/tb_ttl_74299_sync_nohizout.sv
// Directed self-checking bench for ttl_74299_sync_nohizout.
module tb_ttl_74299_sync_nohizout;

  logic       clk;
  logic       rst;
  logic       cen;
  logic       MRn;
  logic       S0;
  logic       S1;
  logic       OE1n;
  logic       OE2n;
  logic       DS0;
  logic       DS7;
  logic [7:0] IO_in;
  logic [7:0] IO_out;
  logic       Q0s;
  logic       Q7s;

  int errors;
  int checks;

  ttl_74299_sync_nohizout dut (
    .clk    (clk),
    .rst    (rst),
    .cen    (cen),
    .MRn    (MRn),
    .S0     (S0),
    .S1     (S1),
    .OE1n   (OE1n),
    .OE2n   (OE2n),
    .DS0    (DS0),
    .DS7    (DS7),
    .IO_in  (IO_in),
    .IO_out (IO_out),
    .Q0s    (Q0s),
    .Q7s    (Q7s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    cen = 1'b1;
    tick();
    cen = 1'b0;
    tick();
  endtask

  task automatic clear_q();
    MRn = 1'b0;
    tick();
    MRn = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; cen = 1'b1; MRn = 1'b1; S1 = 1'b0; S0 = 1'b0;
    OE1n = 1'b0; OE2n = 1'b0; DS0 = 1'b0; DS7 = 1'b0; IO_in = 8'h00;
    tick();
    tick();
    checks++;
    if (IO_out !== 8'h00) begin errors++; $display("FAIL reset_io: got %h want 00", IO_out); end
    checks++;
    if (Q0s !== 1'b0) begin errors++; $display("FAIL reset_q0s: got %b want 0", Q0s); end
    checks++;
    if (Q7s !== 1'b0) begin errors++; $display("FAIL reset_q7s: got %b want 0", Q7s); end
    S0 = 1'b1; DS0 = 1'b1;
    rst = 1'b0;
    tick();
    tick();
    tick();
    S0 = 1'b0;
    #1;
    checks++;
    if (IO_out !== 8'h00) begin errors++; $display("FAIL reset_release_noshift: got %h want 00", IO_out); end
    cen = 1'b0;
    tick();
  endtask

  task automatic test_load();
    S1 = 1'b1; S0 = 1'b1; IO_in = 8'hA5;
    pulse();
    checks++;
    if (IO_out !== 8'hFF) begin errors++; $display("FAIL load_pins_input: got %h want ff", IO_out); end
    checks++;
    if (Q0s !== 1'b1 || Q7s !== 1'b1) begin
      errors++; $display("FAIL load_serial: got %b%b want 11", Q7s, Q0s);
    end
    S1 = 1'b0; S0 = 1'b0;
    #1;
    checks++;
    if (IO_out !== 8'hA5) begin errors++; $display("FAIL load_readback: got %h want a5", IO_out); end
    OE1n = 1'b1;
    #1;
    checks++;
    if (IO_out !== 8'hFF) begin errors++; $display("FAIL oe1n_gate: got %h want ff", IO_out); end
    OE1n = 1'b0;
  endtask

  task automatic test_shift_right();
    logic [7:0] exp;
    clear_q();
    S1 = 1'b0; S0 = 1'b1; DS0 = 1'b1;
    exp = 8'h00;
    for (int i = 0; i < 8; i++) begin
      pulse();
      exp = {exp[6:0], 1'b1};
      checks++;
      if (IO_out !== exp) begin errors++; $display("FAIL shr_step%0d: got %h want %h", i, IO_out, exp); end
      checks++;
      if (Q7s !== (i == 7)) begin errors++; $display("FAIL shr_q7s%0d: got %b want %b", i, Q7s, (i == 7)); end
    end
  endtask

  task automatic test_shift_left();
    S1 = 1'b1; S0 = 1'b1; IO_in = 8'h81;
    pulse();
    S1 = 1'b1; S0 = 1'b0; DS7 = 1'b0;
    #1;
    checks++;
    if (IO_out !== 8'h81 || Q0s !== 1'b1) begin
      errors++; $display("FAIL shl_load: got %h/%b want 81/1", IO_out, Q0s);
    end
    pulse();
    checks++;
    if (IO_out !== 8'h40 || Q0s !== 1'b0) begin
      errors++; $display("FAIL shl_1: got %h/%b want 40/0", IO_out, Q0s);
    end
    pulse();
    checks++;
    if (IO_out !== 8'h20) begin errors++; $display("FAIL shl_2: got %h want 20", IO_out); end
  endtask

  task automatic test_back_to_back();
    clear_q();
    S1 = 1'b0; S0 = 1'b1; DS0 = 1'b1;
    cen = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (IO_out !== 8'h01) begin errors++; $display("FAIL cen_held_one_edge: got %h want 01", IO_out); end
    cen = 1'b0; tick();
    cen = 1'b1; tick();
    cen = 1'b0; tick();
    cen = 1'b1; tick();
    cen = 1'b0; tick();
    checks++;
    if (IO_out !== 8'h07) begin errors++; $display("FAIL cen_b2b_two_edges: got %h want 07", IO_out); end
  endtask

  task automatic test_mode_change();
    S1 = 1'b1; S0 = 1'b0; DS7 = 1'b1;
    tick();
    S1 = 1'b0; S0 = 1'b0;
    tick();
    checks++;
    if (IO_out !== 8'h07) begin errors++; $display("FAIL mode_change_no_edge: got %h want 07", IO_out); end
  endtask

  task automatic test_mrn_clear();
    S1 = 1'b1; S0 = 1'b1; IO_in = 8'h5A;
    MRn = 1'b0; cen = 1'b1;
    tick();
    MRn = 1'b1; cen = 1'b0;
    S1 = 1'b0; S0 = 1'b0;
    tick();
    checks++;
    if (IO_out !== 8'h00) begin errors++; $display("FAIL mrn_beats_edge: got %h want 00", IO_out); end
    OE2n = 1'b1;
    #1;
    checks++;
    if (IO_out !== 8'hFF) begin errors++; $display("FAIL oe2n_gate: got %h want ff", IO_out); end
    checks++;
    if (Q7s !== 1'b0 || Q0s !== 1'b0) begin
      errors++; $display("FAIL mrn_serial: got %b%b want 00", Q7s, Q0s);
    end
    OE2n = 1'b0;
  endtask

  task automatic test_rst_mid_shift();
    S1 = 1'b0; S0 = 1'b1; DS0 = 1'b1;
    pulse();
    pulse();
    checks++;
    if (IO_out !== 8'h03) begin errors++; $display("FAIL pre_rst_shift: got %h want 03", IO_out); end
    cen = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (IO_out !== 8'h00) begin errors++; $display("FAIL rst_mid_shift: got %h want 00", IO_out); end
    cen = 1'b0;
    tick();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_load();
    test_shift_right();
    test_shift_left();
    test_back_to_back();
    test_mode_change();
    test_mrn_clear();
    test_rst_mid_shift();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
